// File: rtl/spine_arb_pkg.sv
// Shared types, default geometry and pointer helper for the spine router
// output-port arbiter.
package spine_arb_pkg;

    localparam int DEF_NUM_PORTS    = 11;
    localparam int DEF_PW           = 4;
    localparam int DEF_LOCK_TIMEOUT = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } port_state_e;

    // Next round-robin start position after idx, wrapping at num_ports.
    function automatic int wrap_next(input int idx, input int num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_PORTS.
module rr_arbiter
    import spine_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PW        = DEF_PW
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic                 valid,
    output logic [PW-1:0]        winner
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [PW:0]            sum;

    // Rotating a doubled copy puts req[(ptr+k) mod N] at bit k, so the lowest
    // set bit of rot is the winner's distance from ptr.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_PORTS-1:0];
        valid = |rot;
        sum   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (PW+1)'(ptr) + (PW+1)'(k);
            end
        end
        if (sum >= (PW+1)'(NUM_PORTS)) begin
            winner = PW'(sum - (PW+1)'(NUM_PORTS));
        end else begin
            winner = sum[PW-1:0];
        end
    end

endmodule

// File: rtl/spine_port_arbiter.sv
// Output-port allocator for the spine router: per-output round-robin lock held
// until the tail flit, with a watchdog that frees outputs whose owner stalls.
module spine_port_arbiter
    import spine_arb_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int PW           = DEF_PW,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS*PW-1:0] req_dest,
    input  logic [NUM_PORTS-1:0]    req_last,
    input  logic [NUM_PORTS-1:0]    out_full,
    input  logic                    err_clr,
    output logic [NUM_PORTS-1:0]    grant,
    output logic [NUM_PORTS-1:0]    out_valid,
    output logic [NUM_PORTS*PW-1:0] out_sel,
    output logic [NUM_PORTS-1:0]    bad_dest,
    output logic [NUM_PORTS-1:0]    timeout_err,
    output logic [NUM_PORTS-1:0]    state_dbg
);

    // Handshake: a flit moves when the locked owner presents it (req_valid with
    // matching req_dest) and out_full is low; grant pops the input FIFO and
    // out_valid pushes the output FIFO in that same cycle, with no ready return.

    localparam int              WD_W    = $clog2(LOCK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 2);

    logic [PW-1:0]                       dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]                dest_bad;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_mat;

    always_comb begin
        dest_bad = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest[i]     = req_dest[i*PW +: PW];
            dest_bad[i] = req_valid[i] && (int'(dest[i]) >= NUM_PORTS);
        end
    end

    assign bad_dest = dest_bad;

    // Out-of-range heads are popped and dropped; they never reach an output.
    always_comb begin
        grant = dest_bad;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant = grant | grant_mat[o];
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        port_state_e          state_q, state_d;
        logic [PW-1:0]        owner_q, owner_d;
        logic [PW-1:0]        ptr_q, ptr_d;
        logic [PW-1:0]        ptr_adv;
        logic [WD_W-1:0]      wdog_q, wdog_d;
        logic                 err_q, err_d;
        logic [NUM_PORTS-1:0] cand;
        logic                 arb_valid;
        logic [PW-1:0]        arb_winner;
        logic                 xfer;
        logic                 fire;

        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[i] = req_valid[i] && (dest[i] == PW'(o));
            end
        end

        rr_arbiter #(
            .NUM_PORTS (NUM_PORTS),
            .PW        (PW)
        ) u_rr (
            .req    (cand),
            .ptr    (ptr_q),
            .valid  (arb_valid),
            .winner (arb_winner)
        );

        always_comb begin
            xfer    = (state_q == LOCKED) && req_valid[owner_q] &&
                      (dest[owner_q] == PW'(o)) && !out_full[o];
            // Firing on the cycle whose increment would reach LOCK_TIMEOUT-1.
            fire    = (state_q == LOCKED) && !xfer && (wdog_q == WD_LAST);
            ptr_adv = PW'(wrap_next(int'(owner_q), NUM_PORTS));
        end

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            wdog_d  = wdog_q;
            err_d   = err_q && !err_clr;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_d = LOCKED;
                        owner_d = arb_winner;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        wdog_d = '0;
                        if (req_last[owner_q]) begin
                            state_d = IDLE;
                            ptr_d   = ptr_adv;
                        end
                    end else if (fire) begin
                        state_d = IDLE;
                        ptr_d   = ptr_adv;
                        wdog_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
                wdog_q  <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
                wdog_q  <= wdog_d;
                err_q   <= err_d;
            end
        end

        assign grant_mat[o]           = xfer ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << owner_q) : '0;
        assign out_valid[o]           = xfer;
        assign out_sel[o*PW +: PW]    = owner_q;
        assign timeout_err[o]         = err_q;
        assign state_dbg[o]           = (state_q == LOCKED);
    end

endmodule

// File: doc/spine_port_arbiter.md
# spine_port_arbiter

Output-port allocator and flit scheduler for the 11-port spine router. It shares each router output port among the input ports that request it. Each output runs round-robin arbitration and holds the grant until the packet's tail flit. It drives the per-port FIFO pop and write strobes between the router ports and the crossbar, and releases any output stuck longer than a watchdog limit.

## Interface
- NUM_PORTS, 11, number of router ports; inputs and outputs are indexed 0..NUM_PORTS-1.
- PW, 4, width of a port index; must satisfy 2^PW >= NUM_PORTS.
- LOCK_TIMEOUT, 64, number of idle cycles a locked output tolerates before forced release; must be >= 2.

Ports:
- clk  in  1  router clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS  input FIFO i has a head flit.
- req_dest  in  NUM_PORTS*PW  destination output index of head flit i; slice i is [i*PW +: PW].
- req_last  in  NUM_PORTS  head flit i is the packet tail.
- out_full  in  NUM_PORTS  output FIFO o cannot accept a flit.
- err_clr  in  1  clears all timeout_err bits.
- grant  out  NUM_PORTS  pop strobe: head flit i is consumed this cycle.
- out_valid  out  NUM_PORTS  write strobe into output FIFO o.
- out_sel  out  NUM_PORTS*PW  input index routed to output o.
- bad_dest  out  NUM_PORTS  pulse when input i is discarded for an out-of-range destination.
- timeout_err  out  NUM_PORTS  sticky flag per output: watchdog fired.

## Operation
- Each output o has a state, an owner[o] (PW bits), a ptr[o] (PW bits) and a wdog[o] counter of $clog2(LOCK_TIMEOUT) bits.
- States: IDLE and LOCKED.
- **IDLE.** The candidates for output o are the inputs with req_valid=1 and req_dest=o. If any candidate exists, o moves to LOCKED on the next edge.
  - owner[o] becomes the first candidate at or after ptr[o], wrapping modulo NUM_PORTS.
  - No flit moves in the arbitration cycle.
- **LOCKED, transfer.** A transfer happens when req_valid[owner]=1, req_dest[owner]=o and out_full[o]=0. In that cycle:
  - grant[owner]=1 and out_valid[o]=1;
  - wdog[o] is cleared.
- **LOCKED, tail.** A transfer with req_last[owner]=1 moves o to IDLE and sets ptr[o]=(owner+1) mod NUM_PORTS.
- **LOCKED, no transfer.** wdog[o] increments. When wdog[o]=LOCK_TIMEOUT-1:
  - o moves to IDLE and ptr[o] advances as above;
  - wdog[o] clears and timeout_err[o] is set.
- **Out-of-range destination.** If req_valid[i]=1 and req_dest[i]>=NUM_PORTS, the arbiter drives grant[i]=1 and bad_dest[i]=1 combinationally in that cycle. The flit is discarded and no out_valid is raised.
- An input targets only one output at a time. Senders hold req_dest constant from the head flit to the tail flit.
- Destination equal to the input's own index (U-turn) is legal.
- out_sel[o] always equals owner[o]. Its value matters only when out_valid[o]=1.
- **err_clr.** Clears every timeout_err bit. If err_clr and a watchdog firing land in the same cycle, the set wins for that output.

## Timing
- grant, out_valid and bad_dest are combinational from registered state plus the current inputs. No combinational path exists from out_full to state.
- Latency from head flit presented at IDLE to first transfer is 1 cycle; the first transfer occurs in the cycle after the request.
- Sustained throughput is one flit per cycle per output while out_full=0.
- Back-to-back packets on one output pay 1 arbitration bubble each.
- out_full=1 stalls the transfer in place. grant stays 0 for that cycle and the flit remains at the head.
- **Reset (asynchronous, active-low).** Every state is IDLE and every owner, ptr and wdog is 0. timeout_err=0.
  - grant, out_valid and bad_dest evaluate to 0 because nothing is locked. The exception is an out-of-range request, which still produces its combinational discard pulse.
  - A packet in flight when reset asserts is abandoned. The sender must flush it.
- **Round-robin bound.** With N contending inputs, each waits at most N-1 packets.

## Structure
- Package spine_arb_pkg holds:
  - the state enum, IDLE=1'b0 and LOCKED=1'b1;
  - the default NUM_PORTS, PW and LOCK_TIMEOUT;
  - a function that computes the next wrapped pointer.
- Sub-module rr_arbiter: one instance per output. It takes a NUM_PORTS request vector and ptr, and returns a valid flag plus a PW-bit winner index. It is purely combinational.
- Per-output state, watchdog and strobe logic live in a generate loop in the top module.

## Test plan
- After reset, input 2 sends a single flit to output 5 with last=1.
  - Next cycle: grant[2]=1, out_valid[5]=1, out_sel[5]=2.
  - Output 5 then returns to IDLE with ptr[5]=3.
- Inputs 0, 3 and 7 each hold continuous 2-flit packets to output 9. Grant order is 0, 3, 7, 0, and each packet moves two contiguous flits.
- A 4-flit packet from input 1 to output 4 with out_full[4]=1 for cycles 2-3. The transfer stalls, grant[1]=0 during the stall, and no flit is lost or duplicated.
- Input 6 locks output 0, sends its head flit, then drops req_valid.
  - After 63 idle cycles: timeout_err[0]=1 and output 0 returns to IDLE.
  - Then assert err_clr: timeout_err[0]=0.
- Input 10 presents req_dest=13. In that cycle grant[10]=1 and bad_dest[10]=1, and out_valid is 0 on every output.
- Assert reset mid-packet on output 8: outputs drop to 0 immediately. After release, a fresh request arbitrates from ptr=0.
